eco32f_div_arb: RTL and testbench

//  Shared serial divide engine with a two-port arbiter and sequencer. Port 0 serves the EX stage
//  (div/rem); port 1 serves a second requester (coprocessor/trap assist). The block arbitrates,

---
 rtl/eco32f_div_arb.sv | 162 ++++++++++++++++
 tb/tb_eco32f_div_arb.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eco32f_div_arb.sv
// eco32f_div_arb: one serial restoring divider shared by two requesters.
// A round-robin arbiter picks a requester. Signed operands are converted
// to magnitudes, the divide runs one bit per cycle, and the sign is
// applied to the result. Only one division is in flight at a time.
module eco32f_div_arb #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          FAST_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req0_rem,
  input  logic             req0_signed,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic             req0_abort,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_rem,
  input  logic             req1_signed,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic             req1_abort,
  output logic             req1_ready,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_dbz,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           state;
  logic             rr_ptr;
  logic             owner;
  logic             op_rem;
  logic             op_dbz;
  logic             op_neg;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] x_raw;
  logic [CW-1:0]    cnt;

  logic             elig0, elig1, grant0, grant1, is_idle;
  logic             sel_rem, sel_signed, sel_neg, sel_dbz;
  logic [WIDTH-1:0] sel_x, sel_y, abs_x, abs_y;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] r_next, n_next;
  logic [WIDTH-1:0] fix_mag, fix_val;
  logic             own_abort;

  // Arbitration, handshake and operand selection for the granted port
  always_comb begin
    elig0      = req0_valid & ~req0_abort;
    elig1      = req1_valid & ~req1_abort;
    grant0     = elig0 & (~elig1 | ~rr_ptr);
    grant1     = elig1 & (~elig0 | rr_ptr);
    is_idle    = (state == S_IDLE);
    req0_ready = is_idle & grant0;
    req1_ready = is_idle & grant1;
    sel_x      = grant1 ? req1_x      : req0_x;
    sel_y      = grant1 ? req1_y      : req0_y;
    sel_rem    = grant1 ? req1_rem    : req0_rem;
    sel_signed = grant1 ? req1_signed : req0_signed;
    abs_x      = (sel_signed & sel_x[WIDTH-1]) ? ('0 - sel_x) : sel_x;
    abs_y      = (sel_signed & sel_y[WIDTH-1]) ? ('0 - sel_y) : sel_y;
    sel_neg    = sel_signed & (sel_rem ? sel_x[WIDTH-1]
                                       : (sel_x[WIDTH-1] ^ sel_y[WIDTH-1]));
    sel_dbz    = (sel_y == '0);
  end

  // One restoring step. The partial remainder is kept one bit wider than the
  // operands so large unsigned divisors cannot overflow the shift.
  always_comb begin
    trial  = {r, n[WIDTH-1]};
    ge     = (trial >= {1'b0, d});
    r_next = ge ? (trial[WIDTH-1:0] - d) : trial[WIDTH-1:0];
    n_next = {n[WIDTH-2:0], ge};
  end

  // Result selection with sign fix-up; divide-by-zero results stay unsigned
  always_comb begin
    fix_mag = op_rem ? r : n;
    if (op_dbz)
      fix_val = op_rem ? x_raw : '1;
    else
      fix_val = op_neg ? ('0 - fix_mag) : fix_mag;
    own_abort = owner ? req1_abort : req0_abort;
  end

  // Response strobes and busy flag decoded from the sequencer state
  always_comb begin
    resp0_valid = (state == S_DONE) & ~owner & ~req0_abort;
    resp1_valid = (state == S_DONE) &  owner & ~req1_abort;
    busy        = ~is_idle;
  end

  // Sequencer: accept, iterate, fix sign, deliver
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      rr_ptr      <= 1'b0;
      owner       <= 1'b0;
      op_rem      <= 1'b0;
      op_dbz      <= 1'b0;
      op_neg      <= 1'b0;
      n           <= '0;
      d           <= '0;
      r           <= '0;
      x_raw       <= '0;
      cnt         <= '0;
      resp_result <= '0;
      resp_dbz    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant0 | grant1) begin
            owner  <= grant1;
            rr_ptr <= ~grant1;
            op_rem <= sel_rem;
            op_dbz <= sel_dbz;
            op_neg <= sel_neg;
            n      <= abs_x;
            d      <= abs_y;
            r      <= '0;
            x_raw  <= sel_x;
            cnt    <= CW'(WIDTH);
            state  <= (sel_dbz & FAST_ZERO) ? S_FIX : S_RUN;
          end
        end
        S_RUN: begin
          if (own_abort) begin
            state <= S_IDLE;
          end else begin
            r   <= r_next;
            n   <= n_next;
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1))
              state <= S_FIX;
          end
        end
        S_FIX: begin
          if (own_abort) begin
            state <= S_IDLE;
          end else begin
            resp_result <= fix_val;
            resp_dbz    <= op_dbz;
            state       <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eco32f_div_arb.sv
// Directed bench for eco32f_div_arb: vector table of single divisions plus
// hand-written arbitration, abort and reset sequences.
module tb_eco32f_div_arb;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_rem, req0_signed, req0_abort, req0_ready;
  logic         req1_valid, req1_rem, req1_signed, req1_abort, req1_ready;
  logic [W-1:0] req0_x, req0_y, req1_x, req1_y;
  logic         resp0_valid, resp1_valid, resp_dbz, busy;
  logic [W-1:0] resp_result;

  always #5 clk = ~clk;

  eco32f_div_arb #(.WIDTH(W), .FAST_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rem(req0_rem), .req0_signed(req0_signed),
    .req0_x(req0_x), .req0_y(req0_y), .req0_abort(req0_abort), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rem(req1_rem), .req1_signed(req1_signed),
    .req1_x(req1_x), .req1_y(req1_y), .req1_abort(req1_abort), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp_result(resp_result), .resp_dbz(resp_dbz), .busy(busy)
  );

  typedef struct {
    bit          port;
    bit          rem;
    bit          sgn;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] res;
    bit          dbz;
    int          lat_lo;
    int          lat_hi;
  } vec_t;

  vec_t vt[16];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit p, input bit v, input bit rem, input bit sgn,
                         input logic [31:0] x, input logic [31:0] y);
    if (!p) begin
      req0_valid = v; req0_rem = rem; req0_signed = sgn; req0_x = x; req0_y = y;
    end else begin
      req1_valid = v; req1_rem = rem; req1_signed = sgn; req1_x = x; req1_y = y;
    end
  endtask

  // Ticks until either response strobe, returns edges elapsed (0 on timeout)
  task automatic wait_resp(output int lat);
    lat = 0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (resp0_valid || resp1_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int e;
    bit seen;
    logic [31:0] prev_res;

    vt[0]  = '{0, 0, 0, 32'd100,        32'd7,          32'd14,         0, 33, 33};
    vt[1]  = '{0, 1, 0, 32'd100,        32'd7,          32'd2,          0, 33, 33};
    vt[2]  = '{1, 1, 1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   0, 33, 33};
    vt[3]  = '{1, 0, 1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   0, 33, 33};
    vt[4]  = '{0, 0, 0, 32'd5,          32'd0,          32'hFFFFFFFF,   1, 1,  2};
    vt[5]  = '{0, 1, 0, 32'd5,          32'd0,          32'd5,          1, 1,  2};
    vt[6]  = '{1, 1, 1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   1, 1,  2};
    vt[7]  = '{1, 0, 1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   0, 33, 33};
    vt[8]  = '{1, 1, 1, 32'h80000000,   32'hFFFFFFFF,   32'd0,          0, 33, 33};
    vt[9]  = '{0, 0, 0, 32'hFFFFFFFF,   32'h10,         32'h0FFFFFFF,   0, 33, 33};
    vt[10] = '{1, 1, 1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   0, 33, 33};
    vt[11] = '{0, 0, 1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   0, 33, 33};
    vt[12] = '{0, 0, 0, 32'hFFFFFFFF,   32'hFFFFFFFE,   32'd1,          0, 33, 33};
    vt[13] = '{0, 1, 0, 32'hFFFFFFFF,   32'hFFFFFFFE,   32'd1,          0, 33, 33};
    vt[14] = '{1, 0, 0, 32'd7,          32'd100,        32'd0,          0, 33, 33};
    vt[15] = '{1, 1, 0, 32'd7,          32'd100,        32'd7,          0, 33, 33};

    rst = 1'b0;
    req0_abort = 1'b0;
    req1_abort = 1'b0;
    set_req(0, 0, 0, 0, '0, '0);
    set_req(1, 0, 0, 0, '0, '0);
    #3;
    chk("rst_busy",   busy,        0);
    chk("rst_result", resp_result, 0);
    chk("rst_dbz",    resp_dbz,    0);
    chk("rst_resp0",  resp0_valid, 0);
    chk("rst_resp1",  resp1_valid, 0);
    chk("rst_ready0", req0_ready,  0);
    chk("rst_ready1", req1_ready,  0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Tie right after reset: port 0 first, port 1 on the next tie
    set_req(0, 1, 0, 0, 32'd100, 32'd7);
    set_req(1, 1, 0, 1, 32'hFFFFFFF9, 32'd2);
    #1;
    chk("tie0_ready0", req0_ready, 1);
    chk("tie0_ready1", req1_ready, 0);
    tick();
    e = 0;
    lat = 0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      e++;
      if (k == 1) begin
        chk("run_busy",   busy,       1);
        chk("run_ready0", req0_ready, 0);
        chk("run_ready1", req1_ready, 0);
      end
      if (resp0_valid || resp1_valid) begin
        lat = k;
        break;
      end
    end
    chk("tie0_lat",    lat,         33);
    chk("tie0_resp0",  resp0_valid, 1);
    chk("tie0_resp1",  resp1_valid, 0);
    chk("tie0_result", resp_result, 32'd14);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      e++;
      if (req1_ready) begin
        seen = 1'b1;
        break;
      end
    end
    chk("tie1_seen",     seen,       1);
    chk("tie1_acc_edge", e + 1,      35);
    chk("tie1_ready0",   req0_ready, 0);
    tick();
    set_req(0, 0, 0, 0, '0, '0);
    set_req(1, 0, 0, 0, '0, '0);
    wait_resp(lat);
    chk("tie1_lat",    lat,         33);
    chk("tie1_resp1",  resp1_valid, 1);
    chk("tie1_resp0",  resp0_valid, 0);
    chk("tie1_result", resp_result, 32'hFFFFFFFD);
    tick();

    // Vector table
    for (int i = 0; i < 16; i++) begin
      set_req(vt[i].port, 1, vt[i].rem, vt[i].sgn, vt[i].x, vt[i].y);
      #1;
      chk($sformatf("v%0d_ready", i), vt[i].port ? req1_ready : req0_ready, 1);
      tick();
      set_req(vt[i].port, 0, 0, 0, '0, '0);
      wait_resp(lat);
      if (vt[i].lat_lo == vt[i].lat_hi)
        chk($sformatf("v%0d_lat", i), lat, vt[i].lat_lo);
      else
        chk($sformatf("v%0d_lat_in_range", i),
            (lat >= vt[i].lat_lo) && (lat <= vt[i].lat_hi), 1);
      chk($sformatf("v%0d_own_valid", i),   vt[i].port ? resp1_valid : resp0_valid, 1);
      chk($sformatf("v%0d_other_valid", i), vt[i].port ? resp0_valid : resp1_valid, 0);
      chk($sformatf("v%0d_result", i), resp_result, vt[i].res);
      chk($sformatf("v%0d_dbz", i),    resp_dbz,    vt[i].dbz);
      tick();
      chk($sformatf("v%0d_idle", i), busy, 0);
    end
    prev_res = vt[15].res;

    // Abort in IDLE only blocks the aborting port
    set_req(0, 1, 0, 0, 32'd9, 32'd3);
    set_req(1, 1, 0, 0, 32'd9, 32'd3);
    req0_abort = 1'b1;
    #1;
    chk("idle_abort_ready0", req0_ready, 0);
    chk("idle_abort_ready1", req1_ready, 1);
    req0_abort = 1'b0;
    set_req(0, 0, 0, 0, '0, '0);
    set_req(1, 0, 0, 0, '0, '0);
    #1;

    // Owner abort during RUN, waiting port 1 granted afterwards
    set_req(0, 1, 0, 0, 32'd100, 32'd7);
    tick();
    set_req(0, 0, 0, 0, '0, '0);
    set_req(1, 1, 1, 1, 32'hFFFFFFF9, 32'd2);
    seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (resp0_valid) seen = 1'b1;
    end
    req0_abort = 1'b1;
    tick();
    if (resp0_valid) seen = 1'b1;
    chk("abort_idle",   busy,        0);
    chk("abort_result", resp_result, prev_res);
    req0_abort = 1'b0;
    #1;
    chk("abort_ready1", req1_ready, 1);
    tick();
    set_req(1, 0, 0, 0, '0, '0);
    req0_abort = 1'b1;
    wait_resp(lat);
    chk("abort_no_resp0", seen,        0);
    chk("nonowner_lat",   lat,         33);
    chk("nonowner_resp1", resp1_valid, 1);
    chk("nonowner_resp0", resp0_valid, 0);
    chk("nonowner_res",   resp_result, 32'hFFFFFFFF);
    req0_abort = 1'b0;
    tick();

    // Abort coinciding with DONE suppresses the strobe
    set_req(0, 1, 1, 0, 32'd100, 32'd7);
    tick();
    set_req(0, 0, 0, 0, '0, '0);
    for (int k = 1; k <= 33; k++) tick();
    chk("done_pre_valid", resp0_valid, 1);
    req0_abort = 1'b1;
    #1;
    chk("done_abort_valid",  resp0_valid, 0);
    chk("done_abort_result", resp_result, 32'd2);
    tick();
    req0_abort = 1'b0;
    chk("done_abort_idle", busy,        0);
    chk("done_abort_v2",   resp0_valid, 0);

    // Reset in the middle of RUN
    set_req(0, 1, 0, 0, 32'd100, 32'd7);
    tick();
    set_req(0, 0, 0, 0, '0, '0);
    for (int k = 1; k <= 20; k++) tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_busy",   busy,        0);
    chk("mid_rst_result", resp_result, 0);
    chk("mid_rst_dbz",    resp_dbz,    0);
    tick();
    tick();
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (resp0_valid || resp1_valid) seen = 1'b1;
    end
    chk("mid_rst_no_resp", seen, 0);
    chk("mid_rst_idle",    busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
